// File: rtl/vga_timing_gen.sv
// Single-clock VGA/LCD raster timing generator with pixel-fetch lookahead and test patterns.
// Requests lead the DAC outputs by RD_LAT+1 cycles so host read data lines up with BLANK.
module vga_timing_gen #(
  parameter int unsigned H_FRONT = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BACK  = 48,
  parameter int unsigned H_ACT   = 640,
  parameter int unsigned V_FRONT = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BACK  = 33,
  parameter int unsigned V_ACT   = 480,
  parameter bit          HS_POL  = 1'b0,
  parameter bit          VS_POL  = 1'b0,
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned CW      = 10,
  parameter int unsigned XW      = 11,
  parameter int unsigned AW      = 22
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic [1:0]    iMode,
  input  logic [CW-1:0] iRed,
  input  logic [CW-1:0] iGreen,
  input  logic [CW-1:0] iBlue,
  output logic          oRequest,
  output logic [XW-1:0] oCurrent_X,
  output logic [XW-1:0] oCurrent_Y,
  output logic [AW-1:0] oAddress,
  output logic          oFrame_Start,
  output logic [CW-1:0] oVGA_R,
  output logic [CW-1:0] oVGA_G,
  output logic [CW-1:0] oVGA_B,
  output logic          oVGA_HS,
  output logic          oVGA_VS,
  output logic          oVGA_BLANK,
  output logic          oVGA_SYNC,
  output logic          oVGA_CLOCK
);

  localparam int unsigned H_BLANK = H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned H_TOTAL = H_BLANK + H_ACT;
  localparam int unsigned V_BLANK = V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned V_TOTAL = V_BLANK + V_ACT;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned BAR_W   = H_ACT / 8;
  localparam int unsigned BW      = $clog2(BAR_W) + 1;
  localparam logic [CW-1:0] GREY  = {1'b1, {(CW-1){1'b0}}};

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_end, v_end;

  logic          act_raw, hs_raw, vs_raw, fs_raw, border_raw;
  logic [HW-1:0] x_raw;
  logic [VW-1:0] y_raw;

  logic          req_q, req_d;
  logic [XW-1:0] x_q, x_d, y_q, y_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          fs_q, fs_d;
  logic          hs_req_q, hs_req_d, vs_req_q, vs_req_d;
  logic          border_q, border_d;
  logic [BW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]    bar_idx_q, bar_idx_d;

  logic [RD_LAT:0] blank_dly_q, blank_dly_d;
  logic [RD_LAT:0] hs_dly_q, hs_dly_d;
  logic [RD_LAT:0] vs_dly_q, vs_dly_d;
  logic [RD_LAT-1:0][3:0] pat_q, pat_d;

  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [CW-1:0] pix_r, pix_g, pix_b;
  logic [2:0]    bar_s;
  logic          brd_s;

  always_comb begin
    h_end   = (h_cnt_q == HW'(H_TOTAL - 1));
    v_end   = (v_cnt_q == VW'(V_TOTAL - 1));
    h_cnt_d = h_end ? '0 : h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_end) begin
      v_cnt_d = v_end ? '0 : v_cnt_q + VW'(1);
    end
  end

  always_comb begin
    act_raw    = (h_cnt_q >= HW'(H_BLANK)) && (v_cnt_q >= VW'(V_BLANK));
    hs_raw     = (h_cnt_q >= HW'(H_FRONT)) && (h_cnt_q < HW'(H_FRONT + H_SYNC));
    vs_raw     = (v_cnt_q >= VW'(V_FRONT)) && (v_cnt_q < VW'(V_FRONT + V_SYNC));
    fs_raw     = (h_cnt_q == HW'(H_BLANK)) && (v_cnt_q == VW'(V_BLANK));
    x_raw      = h_cnt_q - HW'(H_BLANK);
    y_raw      = v_cnt_q - VW'(V_BLANK);
    border_raw = (x_raw == '0) || (x_raw == HW'(H_ACT - 1)) ||
                 (y_raw == '0) || (y_raw == VW'(V_ACT - 1));
  end

  // Request stage: one cycle behind the counters.
  always_comb begin
    req_d     = act_raw;
    x_d       = act_raw ? XW'(x_raw) : '0;
    y_d       = act_raw ? XW'(y_raw) : '0;
    fs_d      = fs_raw;
    hs_req_d  = hs_raw;
    vs_req_d  = vs_raw;
    border_d  = border_raw;
    addr_d    = addr_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (act_raw) begin
      addr_d = fs_raw ? '0 : addr_q + AW'(1);
      if (h_cnt_q == HW'(H_BLANK)) begin
        bar_cnt_d = '0;
        bar_idx_d = '0;
      end else if (bar_cnt_q == BW'(BAR_W - 1)) begin
        bar_cnt_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + BW'(1);
      end
    end
  end

  // Bar/border code only needs to reach the data-sample point, RD_LAT cycles on.
  always_comb begin
    blank_dly_d = {blank_dly_q[RD_LAT-1:0], req_q};
    hs_dly_d    = {hs_dly_q[RD_LAT-1:0], hs_req_q};
    vs_dly_d    = {vs_dly_q[RD_LAT-1:0], vs_req_q};
    pat_d       = pat_q;
    pat_d[0]    = {bar_idx_q, border_q};
    for (int i = 1; i < int'(RD_LAT); i++) begin
      pat_d[i] = pat_q[i-1];
    end
  end

  always_comb begin
    bar_s = pat_q[RD_LAT-1][3:1];
    brd_s = pat_q[RD_LAT-1][0];
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    unique case (mode_q)
      2'd0: begin
        pix_r = iRed;
        pix_g = iGreen;
        pix_b = iBlue;
      end
      2'd1: begin
        pix_r = {CW{~bar_s[1]}};
        pix_g = {CW{~bar_s[2]}};
        pix_b = {CW{~bar_s[0]}};
      end
      2'd2: begin
        pix_r = {CW{brd_s}};
        pix_g = {CW{brd_s}};
        pix_b = {CW{brd_s}};
      end
      2'd3: begin
        pix_r = GREY;
        pix_g = GREY;
        pix_b = GREY;
      end
      default: ;
    endcase
    r_d    = blank_dly_q[RD_LAT-1] ? pix_r : '0;
    g_d    = blank_dly_q[RD_LAT-1] ? pix_g : '0;
    b_d    = blank_dly_q[RD_LAT-1] ? pix_b : '0;
    mode_d = fs_q ? iMode : mode_q;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      req_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      fs_q        <= 1'b0;
      hs_req_q    <= 1'b0;
      vs_req_q    <= 1'b0;
      border_q    <= 1'b0;
      bar_cnt_q   <= '0;
      bar_idx_q   <= '0;
      blank_dly_q <= '0;
      hs_dly_q    <= '0;
      vs_dly_q    <= '0;
      pat_q       <= '0;
      mode_q      <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      req_q       <= req_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      fs_q        <= fs_d;
      hs_req_q    <= hs_req_d;
      vs_req_q    <= vs_req_d;
      border_q    <= border_d;
      bar_cnt_q   <= bar_cnt_d;
      bar_idx_q   <= bar_idx_d;
      blank_dly_q <= blank_dly_d;
      hs_dly_q    <= hs_dly_d;
      vs_dly_q    <= vs_dly_d;
      pat_q       <= pat_d;
      mode_q      <= mode_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
    end
  end

  assign oRequest     = req_q;
  assign oCurrent_X   = x_q;
  assign oCurrent_Y   = y_q;
  assign oAddress     = addr_q;
  assign oFrame_Start = fs_q;
  assign oVGA_R       = r_q;
  assign oVGA_G       = g_q;
  assign oVGA_B       = b_q;
  // Delay stages hold "sync asserted"; polarity is applied only at the pin.
  assign oVGA_HS      = hs_dly_q[RD_LAT] ? HS_POL : ~HS_POL;
  assign oVGA_VS      = vs_dly_q[RD_LAT] ? VS_POL : ~VS_POL;
  assign oVGA_BLANK   = blank_dly_q[RD_LAT];
  assign oVGA_SYNC    = 1'b1;
  assign oVGA_CLOCK   = ~iCLK;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small geometries checked cycle by cycle against a
// raster model derived from pixel index arithmetic (line/frame = index div totals).
module tb_vga_timing_gen;

  localparam int A_HF = 3, A_HS = 5, A_HB = 4, A_HA = 32;
  localparam int A_VF = 2, A_VS = 2, A_VB = 3, A_VA = 12, A_LAT = 3;
  localparam int A_HBL = A_HF + A_HS + A_HB, A_HT = A_HBL + A_HA;
  localparam int A_VBL = A_VF + A_VS + A_VB, A_VT = A_VBL + A_VA;
  localparam int A_FT = A_HT * A_VT;
  localparam int B_HF = 2, B_HS = 3, B_HB = 2, B_HA = 16;
  localparam int B_VF = 1, B_VS = 1, B_VB = 1, B_VA = 4, B_LAT = 1;
  localparam int B_HT = B_HF + B_HS + B_HB + B_HA;

  typedef struct {
    int hf, hs, hb, ha, vf, vs, vb, va;
  } geom_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  mode_a = 2'd0, mode_b = 2'd0;
  logic [9:0]  red_a = '0, green_a = '0, blue_a = '0;
  logic [9:0]  red_b = '0, green_b = '0, blue_b = '0;
  logic        a_req, a_fs, a_hs, a_vs, a_blank, a_sync, a_clock;
  logic [10:0] a_x, a_y;
  logic [21:0] a_addr;
  logic [9:0]  a_r, a_g, a_b;
  logic        b_req, b_fs, b_hs, b_vs, b_blank, b_sync, b_clock;
  logic [10:0] b_x, b_y;
  logic [21:0] b_addr;
  logic [9:0]  b_r, b_g, b_b;

  vga_timing_gen #(
    .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB), .H_ACT(A_HA),
    .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB), .V_ACT(A_VA),
    .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(A_LAT), .CW(10), .XW(11), .AW(22)
  ) u_dut_a (
    .iCLK(clk), .iRST_N(rst_n), .iMode(mode_a), .iRed(red_a), .iGreen(green_a),
    .iBlue(blue_a), .oRequest(a_req), .oCurrent_X(a_x), .oCurrent_Y(a_y),
    .oAddress(a_addr), .oFrame_Start(a_fs), .oVGA_R(a_r), .oVGA_G(a_g), .oVGA_B(a_b),
    .oVGA_HS(a_hs), .oVGA_VS(a_vs), .oVGA_BLANK(a_blank), .oVGA_SYNC(a_sync),
    .oVGA_CLOCK(a_clock)
  );

  vga_timing_gen #(
    .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB), .H_ACT(B_HA),
    .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB), .V_ACT(B_VA),
    .HS_POL(1'b1), .VS_POL(1'b1), .RD_LAT(B_LAT), .CW(10), .XW(11), .AW(22)
  ) u_dut_b (
    .iCLK(clk), .iRST_N(rst_n), .iMode(mode_b), .iRed(red_b), .iGreen(green_b),
    .iBlue(blue_b), .oRequest(b_req), .oCurrent_X(b_x), .oCurrent_Y(b_y),
    .oAddress(b_addr), .oFrame_Start(b_fs), .oVGA_R(b_r), .oVGA_G(b_g), .oVGA_B(b_b),
    .oVGA_HS(b_hs), .oVGA_VS(b_vs), .oVGA_BLANK(b_blank), .oVGA_SYNC(b_sync),
    .oVGA_CLOCK(b_clock)
  );

  int n_checks = 0;
  int n_fail = 0;
  int n = 0;
  int addr_m = 0;
  int req_fr = 0;
  geom_t ga, gb;
  logic [1:0] frame_mode [64];

  logic        e_req, e_fs, e_blank, e_hs, e_vs;
  logic [10:0] e_x, e_y;
  logic [21:0] e_addr;
  logic [9:0]  e_r, e_g, e_b;

  // Pixel index p counts clock cycles since reset release in raster order.
  task automatic pix(input geom_t g, input int p, output bit act, output int x,
                     output int y, output bit hsa, output bit vsa, output int fr);
    int ht, vt, hbl, vbl, h, v, ln;
    hbl = g.hf + g.hs + g.hb;
    vbl = g.vf + g.vs + g.vb;
    ht  = hbl + g.ha;
    vt  = vbl + g.va;
    if (p < 0) begin
      act = 0; x = 0; y = 0; hsa = 0; vsa = 0; fr = 0;
    end else begin
      h   = p % ht;
      ln  = p / ht;
      v   = ln % vt;
      fr  = ln / vt;
      act = (h >= hbl) && (v >= vbl);
      x   = act ? h - hbl : 0;
      y   = act ? v - vbl : 0;
      hsa = (h >= g.hf) && (h < g.hf + g.hs);
      vsa = (v >= g.vf) && (v < g.vf + g.vs);
    end
  endtask

  task automatic reset_model();
    n = 0;
    addr_m = 0;
    for (int i = 0; i < 64; i++) frame_mode[i] = 2'd0;
  endtask

  // Expected DUT A outputs after the n-th clock edge since release.
  task automatic model_a();
    bit act, hsa, vsa;
    int x, y, fr, bar;
    pix(ga, n - 1, act, x, y, hsa, vsa, fr);
    e_req  = act;
    e_x    = 11'(x);
    e_y    = 11'(y);
    e_fs   = act && (x == 0) && (y == 0);
    req_fr = fr;
    if (act) addr_m = y * A_HA + x;
    e_addr = 22'(addr_m);
    pix(ga, n - A_LAT - 2, act, x, y, hsa, vsa, fr);
    e_blank = act;
    e_hs    = !hsa;
    e_vs    = !vsa;
    e_r = '0; e_g = '0; e_b = '0;
    if (act) begin
      case (frame_mode[fr % 64])
        2'd0: begin e_r = red_a; e_g = green_a; e_b = blue_a; end
        2'd1: begin
          bar = x / (A_HA / 8);
          e_r = (bar inside {0, 1, 4, 5}) ? '1 : '0;
          e_g = (bar < 4) ? '1 : '0;
          e_b = (bar % 2 == 0) ? '1 : '0;
        end
        2'd2: begin
          e_r = (x == 0 || x == A_HA - 1 || y == 0 || y == A_VA - 1) ? '1 : '0;
          e_g = e_r; e_b = e_r;
        end
        default: begin e_r = 10'h200; e_g = 10'h200; e_b = 10'h200; end
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    @(negedge clk);
    model_a();
  endtask

  // Host returns X as red for the pixel requested RD_LAT cycles ago; noise otherwise.
  task automatic drive_a(input logic [1:0] m);
    bit act, hsa, vsa;
    int x, y, fr;
    mode_a = m;
    if (e_fs) frame_mode[req_fr % 64] = m;
    pix(ga, n - A_LAT - 1, act, x, y, hsa, vsa, fr);
    red_a   = act ? 10'(x) : 10'($urandom);
    green_a = 10'($urandom);
    blue_a  = 10'($urandom);
  endtask

  task automatic test_reset();
    mode_a = 2'($urandom); red_a = 10'($urandom);
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (a_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", a_req); end
    n_checks++; if (a_addr !== '0) begin n_fail++; $display("FAIL rst_addr got %0d want 0", a_addr); end
    n_checks++; if (a_hs !== 1'b1 || a_vs !== 1'b1) begin
      n_fail++; $display("FAIL rst_sync got hs=%b vs=%b want 1 1", a_hs, a_vs); end
    n_checks++; if (b_hs !== 1'b0 || b_vs !== 1'b0) begin
      n_fail++; $display("FAIL rst_sync_b got hs=%b vs=%b want 0 0", b_hs, b_vs); end
    n_checks++; if (a_blank !== 1'b0 || {a_r, a_g, a_b} !== '0) begin
      n_fail++; $display("FAIL rst_video got blank=%b rgb=%h want 0", a_blank, {a_r, a_g, a_b}); end
    n_checks++; if (a_sync !== 1'b1) begin n_fail++; $display("FAIL sync_pin got %b want 1", a_sync); end
    n_checks++; if (a_clock !== ~clk) begin n_fail++; $display("FAIL clock_pin got %b want %b", a_clock, ~clk); end
    mode_a = 2'd0; red_a = '0;
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
  endtask

  task automatic test_frames();
    int req_cnt, fs_cnt, last_addr, first_req, first_blank, last_fall, blank_start;
    logic prev_hs, prev_blank;
    logic [9:0] prev_r;
    req_cnt = 0; fs_cnt = 0; last_addr = -1; first_req = -1; first_blank = -1;
    last_fall = -1; blank_start = -1; prev_hs = 1'b1; prev_blank = 1'b0; prev_r = '0;
    for (int i = 0; i < 2 * A_FT; i++) begin
      step();
      n_checks++; if (a_req !== e_req) begin n_fail++; $display("FAIL req n=%0d got %b want %b", n, a_req, e_req); end
      n_checks++; if (a_x !== e_x) begin n_fail++; $display("FAIL x n=%0d got %0d want %0d", n, a_x, e_x); end
      n_checks++; if (a_y !== e_y) begin n_fail++; $display("FAIL y n=%0d got %0d want %0d", n, a_y, e_y); end
      n_checks++; if (a_fs !== e_fs) begin n_fail++; $display("FAIL fs n=%0d got %b want %b", n, a_fs, e_fs); end
      n_checks++; if (a_addr !== e_addr) begin n_fail++; $display("FAIL addr n=%0d got %0d want %0d", n, a_addr, e_addr); end
      n_checks++; if (a_blank !== e_blank) begin n_fail++; $display("FAIL blank n=%0d got %b want %b", n, a_blank, e_blank); end
      n_checks++; if (a_hs !== e_hs) begin n_fail++; $display("FAIL hs n=%0d got %b want %b", n, a_hs, e_hs); end
      n_checks++; if (a_vs !== e_vs) begin n_fail++; $display("FAIL vs n=%0d got %b want %b", n, a_vs, e_vs); end
      n_checks++; if (a_r !== e_r) begin n_fail++; $display("FAIL red n=%0d got %0d want %0d", n, a_r, e_r); end
      n_checks++; if (a_g !== e_g) begin n_fail++; $display("FAIL green n=%0d got %0d want %0d", n, a_g, e_g); end
      n_checks++; if (a_b !== e_b) begin n_fail++; $display("FAIL blue n=%0d got %0d want %0d", n, a_b, e_b); end
      if (a_req === 1'b1) begin
        req_cnt++; last_addr = int'(a_addr);
        if (first_req < 0) first_req = n;
      end
      if (a_fs === 1'b1) fs_cnt++;
      if (a_hs === 1'b0 && prev_hs === 1'b1) begin
        if (last_fall >= 0) begin
          n_checks++; if (n - last_fall != A_HT) begin
            n_fail++; $display("FAIL hs_period got %0d want %0d", n - last_fall, A_HT); end
        end
        last_fall = n;
      end
      if (a_hs === 1'b1 && prev_hs === 1'b0) begin
        n_checks++; if (n - last_fall != A_HS) begin
          n_fail++; $display("FAIL hs_width got %0d want %0d", n - last_fall, A_HS); end
      end
      if (a_blank === 1'b1 && prev_blank === 1'b0) begin
        blank_start = n;
        if (first_blank < 0) begin
          first_blank = n;
          n_checks++; if (a_r !== 10'd0) begin
            n_fail++; $display("FAIL first_red got %0d want 0", a_r); end
        end
      end
      if (a_blank === 1'b0 && prev_blank === 1'b1) begin
        n_checks++; if (n - blank_start != A_HA) begin
          n_fail++; $display("FAIL blank_run got %0d want %0d", n - blank_start, A_HA); end
        n_checks++; if (prev_r !== 10'(A_HA - 1)) begin
          n_fail++; $display("FAIL last_red got %0d want %0d", prev_r, A_HA - 1); end
      end
      prev_hs = a_hs; prev_blank = a_blank; prev_r = a_r;
      drive_a(2'd0);
    end
    n_checks++; if (req_cnt != 2 * A_HA * A_VA) begin
      n_fail++; $display("FAIL req_count got %0d want %0d", req_cnt, 2 * A_HA * A_VA); end
    n_checks++; if (fs_cnt != 2) begin n_fail++; $display("FAIL fs_count got %0d want 2", fs_cnt); end
    n_checks++; if (last_addr != A_HA * A_VA - 1) begin
      n_fail++; $display("FAIL last_addr got %0d want %0d", last_addr, A_HA * A_VA - 1); end
    n_checks++; if (first_blank - first_req != A_LAT + 1) begin
      n_fail++; $display("FAIL blank_lead got %0d want %0d", first_blank - first_req, A_LAT + 1); end
    n_checks++; if (first_blank != A_VBL * A_HT + A_HBL + 1 + A_LAT + 1) begin
      n_fail++; $display("FAIL first_blank got %0d want %0d", first_blank,
                         A_VBL * A_HT + A_HBL + 1 + A_LAT + 1); end
  endtask

  // Mid-frame switch to bars, then random modes switched at random mid-frame points.
  task automatic test_modes();
    int s0, s1, s2, base;
    logic [1:0] cur_m, m1, m2;
    base = n;
    s0 = base + A_VBL * A_HT + A_HBL + 1 + 100;
    s1 = base + A_FT + 330 + int'($urandom_range(0, 400));
    s2 = base + 2 * A_FT + 330 + int'($urandom_range(0, 400));
    m1 = 2'($urandom_range(2, 3));
    m2 = 2'($urandom);
    cur_m = 2'd0;
    for (int i = 0; i < 4 * A_FT; i++) begin
      step();
      n_checks++; if (a_blank !== e_blank) begin n_fail++; $display("FAIL m_blank n=%0d got %b want %b", n, a_blank, e_blank); end
      n_checks++; if ({a_r, a_g, a_b} !== {e_r, e_g, e_b}) begin
        n_fail++; $display("FAIL m_rgb n=%0d got %h want %h", n, {a_r, a_g, a_b}, {e_r, e_g, e_b}); end
      if (n == s0) cur_m = 2'd1;
      if (n == s1) cur_m = m1;
      if (n == s2) cur_m = m2;
      drive_a(cur_m);
    end
  endtask

  task automatic test_reset_mid();
    int target, first_hs, first_fs;
    target = n + A_FT - (n % A_FT)
           + (A_VBL + int'($urandom_range(0, A_VA - 1))) * A_HT
           + A_HBL + int'($urandom_range(0, A_HA - 1));
    while (n < target + 1) begin
      step();
      drive_a(2'd0);
    end
    n_checks++; if (a_req !== 1'b1) begin n_fail++; $display("FAIL pre_rst_req got %b want 1", a_req); end
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++; if (a_hs !== 1'b1 || a_vs !== 1'b1 || a_blank !== 1'b0) begin
        n_fail++; $display("FAIL mid_rst_sync got hs=%b vs=%b blank=%b want 1 1 0", a_hs, a_vs, a_blank); end
      n_checks++; if ({a_r, a_g, a_b} !== '0 || a_req !== 1'b0 || a_addr !== '0) begin
        n_fail++; $display("FAIL mid_rst_data got rgb=%h req=%b addr=%0d want 0", {a_r, a_g, a_b}, a_req, a_addr); end
      repeat (5) @(negedge clk);
    end
    rst_n = 1'b1;
    reset_model();
    first_hs = -1; first_fs = -1;
    for (int i = 0; i < A_FT + 10; i++) begin
      step();
      n_checks++; if (a_hs !== e_hs || a_vs !== e_vs) begin
        n_fail++; $display("FAIL r_sync n=%0d got %b%b want %b%b", n, a_hs, a_vs, e_hs, e_vs); end
      n_checks++; if (a_req !== e_req || a_addr !== e_addr || a_fs !== e_fs) begin
        n_fail++; $display("FAIL r_req n=%0d got %b/%0d/%b want %b/%0d/%b", n, a_req, a_addr, a_fs,
                           e_req, e_addr, e_fs); end
      n_checks++; if (a_blank !== e_blank || a_r !== e_r) begin
        n_fail++; $display("FAIL r_video n=%0d got %b/%0d want %b/%0d", n, a_blank, a_r, e_blank, e_r); end
      if (a_hs === 1'b0 && first_hs < 0) first_hs = n;
      if (a_fs === 1'b1 && first_fs < 0) first_fs = n;
      drive_a(2'd0);
    end
    n_checks++; if (first_hs != A_HF + A_LAT + 2) begin
      n_fail++; $display("FAIL first_hs got %0d want %0d", first_hs, A_HF + A_LAT + 2); end
    n_checks++; if (first_fs != A_VBL * A_HT + A_HBL + 1) begin
      n_fail++; $display("FAIL first_fs got %0d want %0d", first_fs, A_VBL * A_HT + A_HBL + 1); end
  endtask

  task automatic test_polarity();
    bit act, hsa, vsa;
    int x, y, fr, max_x, last_rise;
    logic prev_hs;
    max_x = -1; last_rise = -1; prev_hs = b_hs;
    for (int i = 0; i < 400; i++) begin
      step();
      pix(gb, n - 1, act, x, y, hsa, vsa, fr);
      n_checks++; if (b_req !== act || b_x !== 11'(x)) begin
        n_fail++; $display("FAIL b_req n=%0d got %b/%0d want %b/%0d", n, b_req, b_x, act, x); end
      pix(gb, n - B_LAT - 2, act, x, y, hsa, vsa, fr);
      n_checks++; if (b_hs !== hsa || b_vs !== vsa) begin
        n_fail++; $display("FAIL b_sync n=%0d got %b%b want %b%b", n, b_hs, b_vs, hsa, vsa); end
      n_checks++; if (b_blank !== act || b_r !== (act ? red_b : 10'd0)) begin
        n_fail++; $display("FAIL b_video n=%0d got %b/%0d want %b/%0d", n, b_blank, b_r, act,
                           act ? red_b : 10'd0); end
      if (b_req === 1'b1 && int'(b_x) > max_x) max_x = int'(b_x);
      if (b_hs === 1'b1 && prev_hs === 1'b0) begin
        if (last_rise >= 0) begin
          n_checks++; if (n - last_rise != B_HT) begin
            n_fail++; $display("FAIL b_hs_period got %0d want %0d", n - last_rise, B_HT); end
        end
        last_rise = n;
      end
      if (b_hs === 1'b0 && prev_hs === 1'b1) begin
        n_checks++; if (n - last_rise != B_HS) begin
          n_fail++; $display("FAIL b_hs_width got %0d want %0d", n - last_rise, B_HS); end
      end
      prev_hs = b_hs;
      red_b = 10'($urandom);
      drive_a(2'd0);
    end
    n_checks++; if (max_x != B_HA - 1) begin
      n_fail++; $display("FAIL b_max_x got %0d want %0d", max_x, B_HA - 1); end
  endtask

  initial begin
    ga = '{A_HF, A_HS, A_HB, A_HA, A_VF, A_VS, A_VB, A_VA};
    gb = '{B_HF, B_HS, B_HB, B_HA, B_VF, B_VS, B_VB, B_VA};
    reset_model();
    test_reset();
    test_frames();
    test_modes();
    test_reset_mid();
    test_polarity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
